// File: rtl/reg_mtimer.sv
// RISC-V style 64-bit machine timer (mtime/mtimecmp) with prescaler behind a register-interface slot.
// Optional REG_MTIMER_SNAPSHOT_EN: a read of MTIME_LO latches mtime[63:32] for a coherent MTIME_HI read.

package reg_mtimer_pkg;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
    logic                 valid;
  } reg_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  } reg_rsp_t;
endpackage

module reg_mtimer #(
  parameter type         reg_req_t   = reg_mtimer_pkg::reg_req_t,
  parameter type         reg_rsp_t   = reg_mtimer_pkg::reg_rsp_t,
  parameter int unsigned RegAddrBits = 5
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  output logic     time_irq_o
);

  localparam int unsigned PscWidth  = 16;
  localparam int unsigned TimeWidth = 64;

  localparam logic [2:0] IdxCtrl      = 3'd0;
  localparam logic [2:0] IdxPrescale  = 3'd1;
  localparam logic [2:0] IdxMtimeLo   = 3'd2;
  localparam logic [2:0] IdxMtimeHi   = 3'd3;
  localparam logic [2:0] IdxMtimecmpLo = 3'd4;
  localparam logic [2:0] IdxMtimecmpHi = 3'd5;
  localparam logic [2:0] IdxStatus    = 3'd6;

  logic                   r_ctrl_en;
  logic                   r_ctrl_irq_en;
  logic [PscWidth-1:0]    r_prescale;
  logic [PscWidth-1:0]    r_psc_cnt;
  logic [TimeWidth-1:0]   r_mtime;
  logic [TimeWidth-1:0]   r_mtimecmp;
  logic                   r_irq;

  logic                   w_ctrl_en_next;
  logic                   w_ctrl_irq_en_next;
  logic [PscWidth-1:0]    w_prescale_next;
  logic [PscWidth-1:0]    w_psc_cnt_next;
  logic [TimeWidth-1:0]   w_mtime_next;
  logic [TimeWidth-1:0]   w_mtimecmp_next;

  logic [RegAddrBits-1:0] w_off;
  logic [2:0]             w_idx;
  logic                   w_err;
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_tick;
  logic                   w_status;
  logic [31:0]            w_live_word;
  logic [31:0]            w_rd_word;
  logic [31:0]            w_merged;
  logic [31:0]            w_mtime_hi_rd;
  logic                   w_unused_addr;

  // Byte-lane merge of a write into the current register contents.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_unused_addr = ^reg_req_i.addr;

  // Address decode and error classification.
  assign w_off    = reg_req_i.addr[RegAddrBits-1:0];
  assign w_idx    = w_off[4:2];
  assign w_err    = reg_req_i.valid &&
                    ((|w_off[1:0]) || (w_off > RegAddrBits'(24)) ||
                     (reg_req_i.write && (w_idx == IdxStatus)));
  assign w_wr     = reg_req_i.valid && reg_req_i.write && !w_err;
  assign w_rd     = reg_req_i.valid && !reg_req_i.write && !w_err;
  assign w_status = (r_mtime >= r_mtimecmp);
  assign w_tick   = r_ctrl_en && (r_psc_cnt == r_prescale);

  always_comb begin
    w_live_word = '0;
    case (w_idx)
      IdxCtrl:       w_live_word = {30'd0, r_ctrl_irq_en, r_ctrl_en};
      IdxPrescale:   w_live_word = {16'd0, r_prescale};
      IdxMtimeLo:    w_live_word = r_mtime[31:0];
      IdxMtimeHi:    w_live_word = r_mtime[63:32];
      IdxMtimecmpLo: w_live_word = r_mtimecmp[31:0];
      IdxMtimecmpHi: w_live_word = r_mtimecmp[63:32];
      IdxStatus:     w_live_word = {31'd0, w_status};
      default:       w_live_word = '0;
    endcase
  end

  assign w_rd_word = (w_idx == IdxMtimeHi) ? w_mtime_hi_rd : w_live_word;
  assign w_merged  = merge_bytes(w_live_word, reg_req_i.wdata, reg_req_i.wstrb);

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    reg_rsp_o.error = w_err;
    reg_rsp_o.rdata = w_rd ? w_rd_word : '0;
  end

  // Next-state: prescaler tick advances mtime; a bus write to a timer half overrides the tick.
  always_comb begin
    w_ctrl_en_next     = r_ctrl_en;
    w_ctrl_irq_en_next = r_ctrl_irq_en;
    w_prescale_next    = r_prescale;
    w_psc_cnt_next     = r_psc_cnt;
    w_mtime_next       = w_tick ? (r_mtime + 64'd1) : r_mtime;
    w_mtimecmp_next    = r_mtimecmp;
    if (r_ctrl_en) begin
      w_psc_cnt_next = w_tick ? '0 : (r_psc_cnt + 16'd1);
    end
    if (w_wr) begin
      case (w_idx)
        IdxCtrl: begin
          w_ctrl_en_next     = w_merged[0];
          w_ctrl_irq_en_next = w_merged[1];
        end
        IdxPrescale: begin
          w_prescale_next = w_merged[15:0];
          w_psc_cnt_next  = '0;
        end
        IdxMtimeLo:    w_mtime_next    = {r_mtime[63:32], w_merged};
        IdxMtimeHi:    w_mtime_next    = {w_merged, r_mtime[31:0]};
        IdxMtimecmpLo: w_mtimecmp_next = {r_mtimecmp[63:32], w_merged};
        IdxMtimecmpHi: w_mtimecmp_next = {w_merged, r_mtimecmp[31:0]};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ctrl_en     <= 1'b0;
      r_ctrl_irq_en <= 1'b0;
      r_prescale    <= '0;
      r_psc_cnt     <= '0;
      r_mtime       <= '0;
      r_mtimecmp    <= '1;
      r_irq         <= 1'b0;
    end else begin
      r_ctrl_en     <= w_ctrl_en_next;
      r_ctrl_irq_en <= w_ctrl_irq_en_next;
      r_prescale    <= w_prescale_next;
      r_psc_cnt     <= w_psc_cnt_next;
      r_mtime       <= w_mtime_next;
      r_mtimecmp    <= w_mtimecmp_next;
      r_irq         <= w_ctrl_irq_en_next && (w_mtime_next >= w_mtimecmp_next);
    end
  end

`ifdef REG_MTIMER_SNAPSHOT_EN
  logic [31:0] r_mtime_hi_snap;

  // Latch the upper half on a LO read so a following HI read is coherent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtime_hi_snap <= '0;
    end else if (w_rd && (w_idx == IdxMtimeLo)) begin
      r_mtime_hi_snap <= r_mtime[63:32];
    end
  end

  assign w_mtime_hi_rd = r_mtime_hi_snap;
`else
  assign w_mtime_hi_rd = r_mtime[63:32];
`endif

  assign time_irq_o = r_irq;

endmodule

// File: tb/tb_reg_mtimer.sv
// Directed self-checking bench for reg_mtimer: register map, prescaler, carry/wrap, irq, errors, snapshot, reset.
module tb_reg_mtimer;
  import reg_mtimer_pkg::*;

  logic     clk;
  logic     rst_n;
  reg_req_t req;
  reg_rsp_t rsp;
  logic     irq;

  int checks;
  int errors;

  reg_mtimer #(
    .reg_req_t  (reg_req_t),
    .reg_rsp_t  (reg_rsp_t),
    .RegAddrBits(5)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .reg_req_i (req),
    .reg_rsp_o (rsp),
    .time_irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic err, output logic rdy);
    @(negedge clk);
    req.addr  = addr;
    req.write = 1'b1;
    req.wdata = data;
    req.wstrb = strb;
    req.valid = 1'b1;
    #1;
    err = rsp.error;
    rdy = rsp.ready;
    @(posedge clk);
    #1;
    req.valid = 1'b0;
    req.write = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic e, r;
    bus_write(addr, data, 4'hF, e, r);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    @(negedge clk);
    req.addr  = addr;
    req.write = 1'b0;
    req.wdata = 32'd0;
    req.wstrb = 4'h0;
    req.valid = 1'b1;
    #1;
    data = rsp.rdata;
    err  = rsp.error;
    @(posedge clk);
    #1;
    req.valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_v [7];
    logic [31:0] d;
    logic        e;
    exp_v = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    rst_n = 1'b0;
    req   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus_read(32'(i * 4), d, e);
      checks++;
      if (d !== exp_v[i]) begin errors++; $display("FAIL reset_read off=%0h got=%h exp=%h", i * 4, d, exp_v[i]); end
      checks++;
      if (e !== 1'b0) begin errors++; $display("FAIL reset_err off=%0h got=%b exp=0", i * 4, e); end
    end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    logic        e;
    wr(32'h04, 32'd3);
    wr(32'h00, 32'h1);
    repeat (40) @(posedge clk);
    bus_read(32'h08, d, e);
    checks++;
    if (d !== 32'd10) begin errors++; $display("FAIL prescale_count got=%0d exp=10", d); end
    wr(32'h00, 32'h0);
    repeat (20) @(posedge clk);
    bus_read(32'h08, d, e);
    checks++;
    if (d !== 32'd10) begin errors++; $display("FAIL prescale_freeze got=%0d exp=10", d); end
  endtask

  task automatic test_carry();
    logic [31:0] d;
    logic        e;
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'hFFFF_FFFF);
    wr(32'h04, 32'h0);
    wr(32'h00, 32'h1);
    wr(32'h00, 32'h0);
    bus_read(32'h08, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL carry_lo got=%h exp=00000000", d); end
    bus_read(32'h0C, d, e);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL carry_hi got=%h exp=00000001", d); end
    // All-ones wrap, with STATUS at its mtime == mtimecmp boundary first
    wr(32'h08, 32'hFFFF_FFFF);
    wr(32'h0C, 32'hFFFF_FFFF);
    bus_read(32'h18, d, e);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL status_equal got=%h exp=00000001", d); end
    wr(32'h00, 32'h1);
    wr(32'h00, 32'h0);
    bus_read(32'h08, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL wrap_lo got=%h exp=00000000", d); end
    bus_read(32'h0C, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL wrap_hi got=%h exp=00000000", d); end
    bus_read(32'h18, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL status_after_wrap got=%h exp=00000000", d); end
  endtask

  task automatic test_write_vs_tick();
    logic [31:0] d;
    logic        e;
    wr(32'h0C, 32'd5);
    wr(32'h08, 32'hFFFF_FFFF);
    wr(32'h00, 32'h1);
    wr(32'h08, 32'h0000_1234);
    wr(32'h00, 32'h0);
    bus_read(32'h08, d, e);
    checks++;
    if (d !== 32'h0000_1235) begin errors++; $display("FAIL wrtick_lo got=%h exp=00001235", d); end
    bus_read(32'h0C, d, e);
    checks++;
    if (d !== 32'd5) begin errors++; $display("FAIL wrtick_hi got=%h exp=00000005", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    logic        e;
    logic        found;
    wr(32'h10, 32'd100);
    wr(32'h14, 32'd0);
    wr(32'h08, 32'd0);
    wr(32'h0C, 32'd0);
    wr(32'h04, 32'd0);
    wr(32'h00, 32'h3);
    @(negedge clk);
    req.addr  = 32'h08;
    req.write = 1'b0;
    req.valid = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 150 && !found; k++) begin
      @(posedge clk);
      #1;
      if (irq === 1'b1) begin
        found = 1'b1;
        checks++;
        if (rsp.rdata !== 32'd100) begin errors++; $display("FAIL irq_rise_at got=%0d exp=100", rsp.rdata); end
      end
    end
    req.valid = 1'b0;
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL irq_rise_timeout got=0 exp=1");
    end
    wr(32'h10, 32'd200);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop_cmp got=%b exp=0", irq); end
    wr(32'h10, 32'd0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_cmp_zero got=%b exp=1", irq); end
    wr(32'h00, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_en_clear got=%b exp=0", irq); end
    bus_read(32'h18, d, e);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL irq_status got=%h exp=00000001", d); end
    wr(32'h00, 32'h0);
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic        e, r;
    bus_write(32'h1C, 32'hFFFF_FFFF, 4'hF, e, r);
    checks++;
    if (e !== 1'b1 || r !== 1'b1) begin errors++; $display("FAIL err_wr_1c got=%b%b exp=11", e, r); end
    bus_write(32'h02, 32'hFFFF_FFFF, 4'hF, e, r);
    checks++;
    if (e !== 1'b1 || r !== 1'b1) begin errors++; $display("FAIL err_misalign got=%b%b exp=11", e, r); end
    bus_write(32'h18, 32'h0, 4'hF, e, r);
    checks++;
    if (e !== 1'b1 || r !== 1'b1) begin errors++; $display("FAIL err_wr_status got=%b%b exp=11", e, r); end
    bus_read(32'h1C, d, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL err_rd_1c got=%b exp=1", e); end
    bus_read(32'h00, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL err_ctrl_kept got=%h exp=00000000", d); end
    bus_read(32'h10, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL err_cmp_kept got=%h exp=00000000", d); end
    bus_write(32'h00, 32'h3, 4'h0, e, r);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL strb0_irq got=%b exp=0", irq); end
    bus_read(32'h00, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL strb0_ctrl got=%h exp=00000000", d); end
    bus_write(32'h04, 32'hFFFF_FFFF, 4'b0001, e, r);
    bus_read(32'h04, d, e);
    checks++;
    if (d !== 32'h0000_00FF) begin errors++; $display("FAIL strb_prescale got=%h exp=000000ff", d); end
    wr(32'h00, 32'hFFFF_FFFC);
    bus_read(32'h00, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ctrl_unused got=%h exp=00000000", d); end
  endtask

  task automatic test_snapshot();
    logic [31:0] d;
    logic [31:0] exp_hi;
    logic        e;
`ifdef REG_MTIMER_SNAPSHOT_EN
    exp_hi = 32'h0;
`else
    exp_hi = 32'h1;
`endif
    wr(32'h04, 32'h0);
    wr(32'h0C, 32'h0);
    wr(32'h08, 32'hFFFF_FFFE);
    wr(32'h00, 32'h1);
    bus_read(32'h08, d, e);
    checks++;
    if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL snap_lo got=%h exp=fffffffe", d); end
    repeat (5) @(posedge clk);
    bus_read(32'h0C, d, e);
    checks++;
    if (d !== exp_hi) begin errors++; $display("FAIL snap_hi got=%h exp=%h", d, exp_hi); end
    wr(32'h00, 32'h0);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic        e;
    wr(32'h10, 32'h0);
    wr(32'h14, 32'h0);
    wr(32'h00, 32'h2);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got=%b exp=1", irq); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL async_irq got=%b exp=0", irq); end
    req.addr  = 32'h10;
    req.write = 1'b0;
    req.valid = 1'b1;
    #1;
    checks++;
    if (rsp.rdata !== 32'hFFFF_FFFF || rsp.ready !== 1'b1) begin
      errors++; $display("FAIL async_cmp got=%h rdy=%b exp=ffffffff rdy=1", rsp.rdata, rsp.ready);
    end
    req.addr = 32'h00;
    #1;
    checks++;
    if (rsp.rdata !== 32'h0) begin errors++; $display("FAIL async_ctrl got=%h exp=00000000", rsp.rdata); end
    req.valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(32'h04, d, e);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL post_reset_psc got=%h exp=00000000", d); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_prescale();
    test_carry();
    test_write_vs_tick();
    test_irq();
    test_errors();
    test_snapshot();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
